// File: rtl/plab5_mcore_mem_rr_scheduler.sv
// Two-port round-robin front end for a single memory port: one outstanding
// transaction, domain-tagged response routing, and a response watchdog.
module plab5_mcore_mem_rr_scheduler #(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 32,
  parameter int p_ctrl_req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + $clog2(p_data_nbits/8),
  parameter int p_ctrl_resp_nbits = 3 + p_opaque_nbits + 2 + $clog2(p_data_nbits/8),
  parameter int p_timeout         = 255,
  parameter int p_viol_nbits      = 8
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         req0_val,
  output logic                         req0_rdy,
  input  logic [p_ctrl_req_nbits-1:0]  req0_control,
  input  logic [p_data_nbits-1:0]      req0_data,
  input  logic                         req0_domain,

  input  logic                         req1_val,
  output logic                         req1_rdy,
  input  logic [p_ctrl_req_nbits-1:0]  req1_control,
  input  logic [p_data_nbits-1:0]      req1_data,
  input  logic                         req1_domain,

  output logic                         mem_req_val,
  input  logic                         mem_req_rdy,
  output logic [p_ctrl_req_nbits-1:0]  mem_req_control,
  output logic [p_data_nbits-1:0]      mem_req_data,
  output logic                         mem_req_domain,

  input  logic                         mem_resp_val,
  output logic                         mem_resp_rdy,
  input  logic [p_ctrl_resp_nbits-1:0] mem_resp_control,
  input  logic [p_data_nbits-1:0]      mem_resp_data,
  input  logic                         mem_resp_domain,

  output logic                         resp0_val,
  input  logic                         resp0_rdy,
  output logic [p_ctrl_resp_nbits-1:0] resp0_control,
  output logic [p_data_nbits-1:0]      resp0_data,
  output logic                         resp0_domain,
  output logic                         resp0_err,

  output logic                         resp1_val,
  input  logic                         resp1_rdy,
  output logic [p_ctrl_resp_nbits-1:0] resp1_control,
  output logic [p_data_nbits-1:0]      resp1_data,
  output logic                         resp1_domain,
  output logic                         resp1_err,

  output logic [p_viol_nbits-1:0]      viol_count
);

  localparam int CW = (p_timeout < 2) ? 1 : $clog2(p_timeout + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                         state_reg, state_next;
  logic                           ptr_reg;
  logic                           owner_reg;
  logic [p_ctrl_req_nbits-1:0]    req_ctrl_reg;
  logic [p_data_nbits-1:0]        req_data_reg;
  logic                           dom_reg;
  logic [p_ctrl_resp_nbits-1:0]   resp_ctrl_reg;
  logic [p_data_nbits-1:0]        resp_data_reg;
  logic                           err_reg;
  logic [CW-1:0]                  cnt_reg;
  logic [p_viol_nbits-1:0]        viol_reg;

  logic any_val, grant_port, fire, resp_match, resp_bad, timed_out, resp_fire;

  // On a tie the pointer picks; otherwise the lone valid port wins.
  assign any_val    = req0_val | req1_val;
  assign grant_port = (req0_val && req1_val) ? ptr_reg : req1_val;
  assign fire       = (state_reg == IDLE) && any_val;
  assign resp_match = (state_reg == WAIT) && mem_resp_val && (mem_resp_domain == dom_reg);
  assign resp_bad   = (state_reg == WAIT) && mem_resp_val && (mem_resp_domain != dom_reg);
  assign timed_out  = (state_reg == WAIT) && (cnt_reg == CW'(p_timeout));
  assign resp_fire  = (state_reg == RESP) && (owner_reg ? resp1_rdy : resp0_rdy);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_val)                  state_next = ISSUE;
      ISSUE:   if (mem_req_rdy)              state_next = WAIT;
      WAIT:    if (resp_match || timed_out)  state_next = RESP;
      RESP:    if (resp_fire)                state_next = IDLE;
      default:                               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      ptr_reg       <= 1'b0;
      owner_reg     <= 1'b0;
      req_ctrl_reg  <= '0;
      req_data_reg  <= '0;
      dom_reg       <= 1'b0;
      resp_ctrl_reg <= '0;
      resp_data_reg <= '0;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      viol_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (fire) begin
        owner_reg    <= grant_port;
        ptr_reg      <= ~grant_port;
        req_ctrl_reg <= grant_port ? req1_control : req0_control;
        req_data_reg <= grant_port ? req1_data    : req0_data;
        dom_reg      <= grant_port ? req1_domain  : req0_domain;
      end
      if (state_reg == ISSUE && mem_req_rdy)
        cnt_reg <= '0;
      else if (state_reg == WAIT && !timed_out)
        cnt_reg <= cnt_reg + 1'b1;
      // A matching response in the timeout cycle takes precedence.
      if (resp_match) begin
        resp_data_reg <= mem_resp_data;
        resp_ctrl_reg <= mem_resp_control;
        err_reg       <= 1'b0;
      end else if (timed_out) begin
        resp_data_reg <= '0;
        resp_ctrl_reg <= '0;
        err_reg       <= 1'b1;
      end
      if (resp_bad && (viol_reg != {p_viol_nbits{1'b1}}))
        viol_reg <= viol_reg + 1'b1;
    end
  end

  assign req0_rdy        = fire && !grant_port;
  assign req1_rdy        = fire &&  grant_port;

  assign mem_req_val     = (state_reg == ISSUE);
  assign mem_req_control = mem_req_val ? req_ctrl_reg : '0;
  assign mem_req_data    = mem_req_val ? req_data_reg : '0;
  assign mem_req_domain  = mem_req_val && dom_reg;
  assign mem_resp_rdy    = (state_reg == WAIT);

  // Non-owner outputs are forced to zero so nothing leaks across ports.
  assign resp0_val       = (state_reg == RESP) && !owner_reg;
  assign resp0_control   = resp0_val ? resp_ctrl_reg : '0;
  assign resp0_data      = resp0_val ? resp_data_reg : '0;
  assign resp0_domain    = resp0_val && dom_reg;
  assign resp0_err       = resp0_val && err_reg;

  assign resp1_val       = (state_reg == RESP) && owner_reg;
  assign resp1_control   = resp1_val ? resp_ctrl_reg : '0;
  assign resp1_data      = resp1_val ? resp_data_reg : '0;
  assign resp1_domain    = resp1_val && dom_reg;
  assign resp1_err       = resp1_val && err_reg;

  assign viol_count      = viol_reg;

endmodule

// File: tb/tb_plab5_mcore_mem_rr_scheduler.sv
// Directed and randomized transactions against a transaction-level model of
// the round-robin memory scheduler.
module tb_plab5_mcore_mem_rr_scheduler;
  localparam int TO = 4;
  localparam int CQ = 45;
  localparam int CR = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic req0_val, req0_rdy, req0_domain, req1_val, req1_rdy, req1_domain;
  logic [CQ-1:0] req0_control, req1_control, mem_req_control;
  logic [31:0] req0_data, req1_data, mem_req_data, mem_resp_data, resp0_data, resp1_data;
  logic mem_req_val, mem_req_rdy, mem_req_domain;
  logic mem_resp_val, mem_resp_rdy, mem_resp_domain;
  logic [CR-1:0] mem_resp_control, resp0_control, resp1_control;
  logic resp0_val, resp0_rdy, resp0_domain, resp0_err;
  logic resp1_val, resp1_rdy, resp1_domain, resp1_err;
  logic [7:0] viol_count;

  plab5_mcore_mem_rr_scheduler #(
    .p_ctrl_req_nbits(CQ), .p_ctrl_resp_nbits(CR), .p_timeout(TO), .p_viol_nbits(8)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_control(req0_control),
    .req0_data(req0_data), .req0_domain(req0_domain),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_control(req1_control),
    .req1_data(req1_data), .req1_domain(req1_domain),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_control(mem_req_control),
    .mem_req_data(mem_req_data), .mem_req_domain(mem_req_domain),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_control(mem_resp_control),
    .mem_resp_data(mem_resp_data), .mem_resp_domain(mem_resp_domain),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_control(resp0_control),
    .resp0_data(resp0_data), .resp0_domain(resp0_domain), .resp0_err(resp0_err),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_control(resp1_control),
    .resp1_data(resp1_data), .resp1_domain(resp1_domain), .resp1_err(resp1_err),
    .viol_count(viol_count)
  );

  int checks = 0;
  int errors = 0;
  bit ptr_m  = 1'b0;   // port that wins the next tie
  int viol_m = 0;      // expected count of dropped responses

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_req_val"}, mem_req_val, 0);
    chk({tag, ".mem_req_control"}, mem_req_control, 0);
    chk({tag, ".mem_req_data"}, mem_req_data, 0);
    chk({tag, ".mem_req_domain"}, mem_req_domain, 0);
    chk({tag, ".mem_resp_rdy"}, mem_resp_rdy, 0);
    chk({tag, ".req_rdy"}, {req0_rdy, req1_rdy}, 0);
    chk({tag, ".resp_val"}, {resp0_val, resp1_val}, 0);
    chk({tag, ".resp_data"}, {resp0_data, resp1_data}, 0);
    chk({tag, ".resp_control"}, {resp0_control, resp1_control}, 0);
    chk({tag, ".resp_dom_err"}, {resp0_domain, resp0_err, resp1_domain, resp1_err}, 0);
    chk({tag, ".viol_count"}, viol_count, 0);
  endtask

  // One full transaction: grant, issue (with stalls), wait (with mismatches
  // or silence), response (with back-pressure), return to idle.
  task automatic do_txn(input bit v0, input bit v1, input bit dom0, input bit dom1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] rd,
                        input int req_stall, input int n_bad, input bit silent,
                        input int resp_stall, input string tag);
    logic [CQ-1:0] c0, c1, ec;
    logic [CR-1:0] rc, oc;
    logic [31:0] ed, od;
    bit own, dom, done;
    int nb;
    c0 = CQ'({$urandom(), $urandom()});
    c1 = CQ'({$urandom(), $urandom()});
    rc = CR'($urandom());
    req0_val = v0; req0_control = c0; req0_data = d0; req0_domain = dom0;
    req1_val = v1; req1_control = c1; req1_data = d1; req1_domain = dom1;
    own = (v0 && v1) ? ptr_m : v1;
    #1;
    chk({tag, ".req0_rdy"}, req0_rdy, !own);
    chk({tag, ".req1_rdy"}, req1_rdy, own);
    tick();
    ptr_m = !own;
    if (own) req1_val = 1'b0; else req0_val = 1'b0;
    ec  = own ? c1 : c0;
    ed  = own ? d1 : d0;
    dom = own ? dom1 : dom0;

    for (int i = 0; i <= req_stall; i++) begin
      mem_req_rdy = (i == req_stall);
      #1;
      chk({tag, ".mem_req_val"}, mem_req_val, 1);
      chk({tag, ".mem_req_control"}, mem_req_control, ec);
      chk({tag, ".mem_req_data"}, mem_req_data, ed);
      chk({tag, ".mem_req_domain"}, mem_req_domain, dom);
      chk({tag, ".issue_req_rdy"}, {req0_rdy, req1_rdy}, 0);
      chk({tag, ".issue_resp_rdy"}, mem_resp_rdy, 0);
      tick();
    end
    mem_req_rdy = 1'b0;

    done = 1'b0;
    nb = 0;
    for (int i = 0; i <= TO && !done; i++) begin
      chk({tag, ".wait_resp_rdy"}, mem_resp_rdy, 1);
      chk({tag, ".wait_resp_val"}, {resp0_val, resp1_val, mem_req_val}, 0);
      mem_resp_control = CR'($urandom());
      mem_resp_data    = $urandom();
      if (i < n_bad) begin
        mem_resp_val = 1'b1; mem_resp_domain = !dom; nb++;
      end else if (!silent) begin
        mem_resp_val = 1'b1; mem_resp_domain = dom;
        mem_resp_data = rd; mem_resp_control = rc; done = 1'b1;
      end else begin
        mem_resp_val = 1'b0;
      end
      tick();
      mem_resp_val = 1'b0;
    end
    viol_m = (viol_m + nb > 255) ? 255 : viol_m + nb;
    od = silent ? 32'h0 : rd;
    oc = silent ? '0 : rc;

    for (int i = 0; i <= resp_stall; i++) begin
      if (own) resp1_rdy = (i == resp_stall); else resp0_rdy = (i == resp_stall);
      #1;
      chk({tag, ".resp0_val"}, resp0_val, !own);
      chk({tag, ".resp1_val"}, resp1_val, own);
      chk({tag, ".resp0_data"}, resp0_data, own ? 32'h0 : od);
      chk({tag, ".resp1_data"}, resp1_data, own ? od : 32'h0);
      chk({tag, ".resp0_control"}, resp0_control, own ? '0 : oc);
      chk({tag, ".resp1_control"}, resp1_control, own ? oc : '0);
      chk({tag, ".resp_err"}, {resp0_err, resp1_err}, own ? {1'b0, silent} : {silent, 1'b0});
      chk({tag, ".resp_domain"}, {resp0_domain, resp1_domain}, own ? {1'b0, dom} : {dom, 1'b0});
      chk({tag, ".resp_mem_rdy"}, {mem_resp_rdy, mem_req_val, req0_rdy, req1_rdy}, 0);
      tick();
    end
    resp0_rdy = 1'b0; resp1_rdy = 1'b0;
    req0_val = 1'b0; req1_val = 1'b0;
    #1;
    chk({tag, ".idle_val"}, {resp0_val, resp1_val, mem_req_val, mem_resp_rdy}, 0);
    chk({tag, ".viol_count"}, viol_count, viol_m);
    $display("txn %s owner=%0d err=%0d data=%08h viol=%0d", tag, own, silent, od, viol_m);
  endtask

  initial begin
    int r;
    reset = 1'b0;
    req0_val = 0; req0_control = '0; req0_data = '0; req0_domain = 0;
    req1_val = 0; req1_control = '0; req1_data = '0; req1_domain = 0;
    mem_req_rdy = 0; mem_resp_val = 0; mem_resp_control = '0; mem_resp_data = '0;
    mem_resp_domain = 0; resp0_rdy = 0; resp1_rdy = 0;
    #2;
    chk_zero("reset");
    tick(); tick();
    reset = 1'b1;
    #1;
    chk_zero("post_reset");

    do_txn(1, 0, 0, 0, 32'hA5, 32'h0, 32'h5A, 0, 0, 0, 0, "single");
    for (int k = 0; k < 4; k++)
      do_txn(1, 1, 0, 1, $urandom(), $urandom(), $urandom(), 0, 0, 0, 0, "contention");
    do_txn(0, 1, 0, 1, 32'h0, 32'h11, 32'h77, 0, 1, 0, 0, "mismatch");
    do_txn(1, 0, 0, 0, 32'h22, 32'h0, 32'h0, 0, 0, 1, 0, "timeout");
    do_txn(1, 0, 1, 0, 32'h33, 32'h0, 32'h44, 0, 0, 0, 0, "after_timeout");
    do_txn(1, 0, 0, 0, 32'h55, 32'h0, 32'h66, 3, 0, 0, 2, "backpressure");

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(1, 3);
      do_txn(r[0], r[1], 1'($urandom()), 1'($urandom()), $urandom(), $urandom(), $urandom(),
             $urandom_range(0, 3), $urandom_range(0, TO), ($urandom_range(0, 3) == 0),
             $urandom_range(0, 2), "random");
    end

    // Abort a transaction in WAIT with an asynchronous reset pulse.
    req0_val = 1; req1_val = 1;
    tick();
    req0_val = 0; req1_val = 0; mem_req_rdy = 1;
    tick();
    mem_req_rdy = 0;
    #1;
    chk("abort.in_wait", mem_resp_rdy, 1);
    reset = 1'b0;
    #1;
    chk_zero("abort");
    tick();
    reset = 1'b1;
    ptr_m = 1'b0;
    viol_m = 0;
    #1;
    do_txn(1, 1, 0, 1, 32'h99, 32'hAA, 32'hBB, 0, 0, 0, 0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit");
  end
endmodule
